wb_addr_decoder: RTL and testbench

WB_ADDR_DECODER -- requirements
Module: wb_addr_decoder

---
 rtl/wb_decoder_pkg.sv | 42 ++++
 rtl/wb_decoder_timeout.sv | 29 ++
 rtl/wb_addr_decoder.sv | 188 ++++++++++++++++++
 tb/tb_wb_addr_decoder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_decoder_pkg.sv
// rtl/wb_decoder_pkg.sv - shared types, constants and decode helpers for the Wishbone address decoder
package wb_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RESP   = 2'd2,
        ST_ERR    = 2'd3
    } state_t;

    localparam int unsigned SLAVE_COUNT = 3;

    localparam logic [31:0] DEF_S0_BASE = 32'h0000_0000;
    localparam logic [31:0] DEF_S0_MASK = 32'hFFF0_0000;
    localparam logic [31:0] DEF_S1_BASE = 32'h4000_0000;
    localparam logic [31:0] DEF_S1_MASK = 32'hFFFF_F000;
    localparam logic [31:0] DEF_S2_BASE = 32'h4000_1000;
    localparam logic [31:0] DEF_S2_MASK = 32'hFFFF_F000;

    // Read data returned to the master on a bus error.
    localparam logic [31:0] ERR_PATTERN = 32'h0000_DEAD;

    // Address window match: masked address equals the slave base.
    function automatic logic addr_hit(input logic [31:0] adr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
        return (adr & mask) == base;
    endfunction

    // Lowest-numbered hit wins, so overlapping windows resolve S0 > S1 > S2.
    function automatic logic [SLAVE_COUNT-1:0] pick_slave(input logic [SLAVE_COUNT-1:0] hits);
        logic [SLAVE_COUNT-1:0] onehot;
        onehot = '0;
        for (int i = 0; i < SLAVE_COUNT; i++) begin
            if (hits[i] && onehot == '0) begin
                onehot[i] = 1'b1;
            end
        end
        return onehot;
    endfunction

endpackage

// File: rtl/wb_decoder_timeout.sv
// rtl/wb_decoder_timeout.sv - slave acknowledge watchdog counter used when WB_DECODER_TIMEOUT_EN is defined
module wb_decoder_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    // Count cycles spent waiting; the last waiting cycle raises expired combinationally.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_addr_decoder.sv
// rtl/wb_addr_decoder.sv - single-master, three-slave Wishbone address decoder; optional ACK timeout via WB_DECODER_TIMEOUT_EN
module wb_addr_decoder
    import wb_decoder_pkg::*;
#(
    parameter logic [31:0] S0_BASE        = DEF_S0_BASE,
    parameter logic [31:0] S0_MASK        = DEF_S0_MASK,
    parameter logic [31:0] S1_BASE        = DEF_S1_BASE,
    parameter logic [31:0] S1_MASK        = DEF_S1_MASK,
    parameter logic [31:0] S2_BASE        = DEF_S2_BASE,
    parameter logic [31:0] S2_MASK        = DEF_S2_MASK,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                   CLK_I,
    input  logic                   RST_I,
    input  logic [31:0]            M_ADR_I,
    input  logic [31:0]            M_DAT_I,
    input  logic [3:0]             M_SEL_I,
    input  logic                   M_CYC_I,
    input  logic                   M_STB_I,
    input  logic                   M_WE_I,
    output logic [31:0]            M_DAT_O,
    output logic                   M_ACK_O,
    output logic                   M_ERR_O,
    output logic [31:0]            S_ADR_O,
    output logic [31:0]            S_DAT_O,
    output logic [3:0]             S_SEL_O,
    output logic                   S_WE_O,
    output logic [SLAVE_COUNT-1:0] S_CYC_O,
    output logic [SLAVE_COUNT-1:0] S_STB_O,
    input  logic [SLAVE_COUNT-1:0] S_ACK_I,
    input  logic [31:0]            S0_DAT_I,
    input  logic [31:0]            S1_DAT_I,
    input  logic [31:0]            S2_DAT_I
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("wb_addr_decoder: TIMEOUT_CYCLES must be at least 1");
    end

    state_t                 state_q;
    state_t                 state_next;
    logic [SLAVE_COUNT-1:0] strb_q;
    logic [SLAVE_COUNT-1:0] strb_next;
    logic [31:0]            mdat_q;
    logic [31:0]            mdat_next;
    logic [31:0]            adr_q;
    logic [31:0]            dat_q;
    logic [3:0]             sel_q;
    logic                   we_q;
    logic                   load;

    logic                   req;
    logic [SLAVE_COUNT-1:0] hits;
    logic [SLAVE_COUNT-1:0] dec;
    logic                   sel_ack;
    logic [31:0]            slave_dat;
    logic                   tmo_expired;

    assign req  = M_CYC_I & M_STB_I;
    assign hits = {addr_hit(M_ADR_I, S2_BASE, S2_MASK),
                   addr_hit(M_ADR_I, S1_BASE, S1_MASK),
                   addr_hit(M_ADR_I, S0_BASE, S0_MASK)};
    assign dec  = pick_slave(hits);

    // Only the strobed slave may complete the cycle; stray ACKs from others are masked off.
    assign sel_ack = |(S_ACK_I & strb_q);

    // Return-data mux keyed by the latched one-hot slave select.
    always_comb begin
        slave_dat = '0;
        if (strb_q[0]) begin
            slave_dat = S0_DAT_I;
        end else if (strb_q[1]) begin
            slave_dat = S1_DAT_I;
        end else if (strb_q[2]) begin
            slave_dat = S2_DAT_I;
        end
    end

`ifdef WB_DECODER_TIMEOUT_EN
    logic tmo_clear;
    logic tmo_enable;

    // Counter is held at zero outside ACTIVE so every transaction starts fresh.
    assign tmo_clear  = (state_q != ST_ACTIVE);
    assign tmo_enable = (state_q == ST_ACTIVE);

    wb_decoder_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (CLK_I),
        .resetn  (RST_I),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Next-state and datapath-update decisions; abort beats ACK beats timeout in ACTIVE.
    always_comb begin
        state_next = state_q;
        strb_next  = strb_q;
        mdat_next  = mdat_q;
        load       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    load = 1'b1;
                    if (|dec) begin
                        strb_next  = dec;
                        state_next = ST_ACTIVE;
                    end else begin
                        strb_next  = '0;
                        mdat_next  = ERR_PATTERN;
                        state_next = ST_ERR;
                    end
                end
            end
            ST_ACTIVE: begin
                if (!M_CYC_I) begin
                    strb_next  = '0;
                    state_next = ST_IDLE;
                end else if (sel_ack) begin
                    strb_next  = '0;
                    mdat_next  = slave_dat;
                    state_next = ST_RESP;
                end else if (tmo_expired) begin
                    strb_next  = '0;
                    mdat_next  = ERR_PATTERN;
                    state_next = ST_ERR;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            ST_ERR: begin
                state_next = ST_IDLE;
            end
            default: begin
                strb_next  = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // Slave-side request registers and master read-data register.
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            strb_q <= '0;
            mdat_q <= '0;
            adr_q  <= '0;
            dat_q  <= '0;
            sel_q  <= '0;
            we_q   <= 1'b0;
        end else begin
            strb_q <= strb_next;
            mdat_q <= mdat_next;
            if (load) begin
                adr_q <= M_ADR_I;
                dat_q <= M_DAT_I;
                sel_q <= M_SEL_I;
                we_q  <= M_WE_I;
            end
        end
    end

    assign S_CYC_O = strb_q;
    assign S_STB_O = strb_q;
    assign S_ADR_O = adr_q;
    assign S_DAT_O = dat_q;
    assign S_SEL_O = sel_q;
    assign S_WE_O  = we_q;
    assign M_DAT_O = mdat_q;
    assign M_ACK_O = (state_q == ST_RESP);
    assign M_ERR_O = (state_q == ST_ERR);

endmodule

// File: tb/tb_wb_addr_decoder.sv
// tb/tb_wb_addr_decoder.sv - directed self-checking bench for wb_addr_decoder (both WB_DECODER_TIMEOUT_EN builds)
module tb_wb_addr_decoder;

    logic        CLK_I = 1'b0;
    logic        RST_I;
    logic [31:0] M_ADR_I, M_DAT_I;
    logic [3:0]  M_SEL_I;
    logic        M_CYC_I, M_STB_I, M_WE_I;
    logic [31:0] M_DAT_O;
    logic        M_ACK_O, M_ERR_O;
    logic [31:0] S_ADR_O, S_DAT_O;
    logic [3:0]  S_SEL_O;
    logic        S_WE_O;
    logic [2:0]  S_CYC_O, S_STB_O, S_ACK_I;
    logic [31:0] S0_DAT_I, S1_DAT_I, S2_DAT_I;

    int total = 0;
    int bad   = 0;

    wb_addr_decoder dut (
        .CLK_I    (CLK_I),
        .RST_I    (RST_I),
        .M_ADR_I  (M_ADR_I),
        .M_DAT_I  (M_DAT_I),
        .M_SEL_I  (M_SEL_I),
        .M_CYC_I  (M_CYC_I),
        .M_STB_I  (M_STB_I),
        .M_WE_I   (M_WE_I),
        .M_DAT_O  (M_DAT_O),
        .M_ACK_O  (M_ACK_O),
        .M_ERR_O  (M_ERR_O),
        .S_ADR_O  (S_ADR_O),
        .S_DAT_O  (S_DAT_O),
        .S_SEL_O  (S_SEL_O),
        .S_WE_O   (S_WE_O),
        .S_CYC_O  (S_CYC_O),
        .S_STB_O  (S_STB_O),
        .S_ACK_I  (S_ACK_I),
        .S0_DAT_I (S0_DAT_I),
        .S1_DAT_I (S1_DAT_I),
        .S2_DAT_I (S2_DAT_I)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK_I);
        @(negedge CLK_I);
    endtask

    task automatic req(input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic we);
        M_ADR_I = adr; M_DAT_I = dat; M_SEL_I = sel; M_WE_I = we;
        M_CYC_I = 1'b1; M_STB_I = 1'b1;
    endtask

    task automatic idle_master();
        M_CYC_I = 1'b0; M_STB_I = 1'b0; M_WE_I = 1'b0;
    endtask

    initial begin
        RST_I = 1'b0;
        M_ADR_I = '0; M_DAT_I = '0; M_SEL_I = '0;
        M_CYC_I = 1'b0; M_STB_I = 1'b0; M_WE_I = 1'b0;
        S_ACK_I = '0; S0_DAT_I = '0; S1_DAT_I = '0; S2_DAT_I = '0;
        cyc(); cyc();

        // Reset state
        chk("rst_ack",  {31'd0, M_ACK_O}, 32'd0);
        chk("rst_err",  {31'd0, M_ERR_O}, 32'd0);
        chk("rst_mdat", M_DAT_O, 32'd0);
        chk("rst_stb",  {29'd0, S_STB_O}, 32'd0);
        chk("rst_cyc",  {29'd0, S_CYC_O}, 32'd0);
        chk("rst_we",   {31'd0, S_WE_O}, 32'd0);
        chk("rst_adr",  S_ADR_O, 32'd0);
        chk("rst_sdat", S_DAT_O, 32'd0);
        chk("rst_sel",  {28'd0, S_SEL_O}, 32'd0);
        RST_I = 1'b1;
        cyc();

        // Read from S0, zero-wait ACK
        req(32'h0000_0010, 32'h0, 4'b1111, 1'b0);
        cyc();
        chk("rd_stb",  {29'd0, S_STB_O}, 32'h1);
        chk("rd_cyc",  {29'd0, S_CYC_O}, 32'h1);
        chk("rd_adr",  S_ADR_O, 32'h0000_0010);
        chk("rd_sel",  {28'd0, S_SEL_O}, 32'hF);
        chk("rd_noack", {31'd0, M_ACK_O}, 32'd0);
        S_ACK_I = 3'b001; S0_DAT_I = 32'h1234_5678; S1_DAT_I = 32'h1111_1111;
        cyc();
        chk("rd_ack",  {31'd0, M_ACK_O}, 32'h1);
        chk("rd_mdat", M_DAT_O, 32'h1234_5678);
        chk("rd_stb_off", {29'd0, S_STB_O}, 32'd0);
        idle_master(); S_ACK_I = '0;
        cyc();
        chk("rd_ack_1cyc", {31'd0, M_ACK_O}, 32'd0);

        // Write to S1 with one wait state
        req(32'h4000_0004, 32'h0000_00A5, 4'b0001, 1'b1);
        cyc();
        chk("wr_stb",  {29'd0, S_STB_O}, 32'h2);
        chk("wr_we",   {31'd0, S_WE_O}, 32'h1);
        chk("wr_sdat", S_DAT_O, 32'h0000_00A5);
        chk("wr_sel",  {28'd0, S_SEL_O}, 32'h1);
        cyc();
        chk("wr_wait_stb", {29'd0, S_STB_O}, 32'h2);
        chk("wr_wait_ack", {31'd0, M_ACK_O}, 32'd0);
        S_ACK_I = 3'b010;
        cyc();
        chk("wr_ack", {31'd0, M_ACK_O}, 32'h1);
        idle_master(); S_ACK_I = '0;
        cyc();

        // Unmapped address
        req(32'h8000_0000, 32'h0, 4'b1111, 1'b0);
        cyc();
        chk("miss_stb",  {29'd0, S_STB_O}, 32'd0);
        chk("miss_err",  {31'd0, M_ERR_O}, 32'h1);
        chk("miss_ack",  {31'd0, M_ACK_O}, 32'd0);
        chk("miss_mdat", M_DAT_O, 32'h0000_DEAD);
        idle_master();
        cyc();
        chk("miss_err_1cyc", {31'd0, M_ERR_O}, 32'd0);

        // Window edges: just past S0, last word of S1, and a gap above S2
        req(32'h0010_0000, 32'h0, 4'b1111, 1'b0);
        cyc();
        chk("s0_edge_err", {31'd0, M_ERR_O}, 32'h1);
        idle_master();
        cyc();
        req(32'h4000_0FFC, 32'h0, 4'b0101, 1'b0);
        cyc();
        chk("s1_edge_stb", {29'd0, S_STB_O}, 32'h2);
        chk("s1_edge_sel", {28'd0, S_SEL_O}, 32'h5);
        S_ACK_I = 3'b010; S1_DAT_I = 32'h0BAD_F00D;
        cyc();
        chk("s1_edge_mdat", M_DAT_O, 32'h0BAD_F00D);
        idle_master(); S_ACK_I = '0;
        cyc();
        req(32'h4000_2000, 32'h0, 4'b1111, 1'b0);
        cyc();
        chk("gap_err", {31'd0, M_ERR_O}, 32'h1);
        chk("gap_stb", {29'd0, S_STB_O}, 32'd0);
        idle_master();
        cyc();

        // Stray ACK from S1 during S0 transaction
        req(32'h0000_0020, 32'h0, 4'b0011, 1'b0);
        cyc();
        chk("stray_stb", {29'd0, S_STB_O}, 32'h1);
        S_ACK_I = 3'b010; S1_DAT_I = 32'h0000_BAD1;
        cyc();
        chk("stray_noack", {31'd0, M_ACK_O}, 32'd0);
        chk("stray_stb_hold", {29'd0, S_STB_O}, 32'h1);
        S_ACK_I = 3'b011; S0_DAT_I = 32'hCAFE_F00D;
        cyc();
        chk("stray_ack", {31'd0, M_ACK_O}, 32'h1);
        chk("stray_mdat", M_DAT_O, 32'hCAFE_F00D);
        idle_master(); S_ACK_I = '0;
        cyc();

        // Silent S2
        req(32'h4000_1000, 32'h0, 4'b1111, 1'b0);
`ifdef WB_DECODER_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            cyc();
            chk("tmo_wait_stb", {29'd0, S_STB_O}, 32'h4);
            chk("tmo_wait_err", {31'd0, M_ERR_O}, 32'd0);
        end
        cyc();
        chk("tmo_err",  {31'd0, M_ERR_O}, 32'h1);
        chk("tmo_stb",  {29'd0, S_STB_O}, 32'd0);
        chk("tmo_mdat", M_DAT_O, 32'h0000_DEAD);
        idle_master();
        cyc();
        chk("tmo_err_1cyc", {31'd0, M_ERR_O}, 32'd0);
`else
        for (int i = 0; i < 24; i++) begin
            cyc();
            chk("wait_stb", {29'd0, S_STB_O}, 32'h4);
            chk("wait_err", {31'd0, M_ERR_O}, 32'd0);
        end
        idle_master();
        cyc();
        chk("wait_abort_stb", {29'd0, S_STB_O}, 32'd0);
`endif

        // Master abort two cycles into ACTIVE
        req(32'h4000_1004, 32'h0, 4'b1111, 1'b0);
        cyc();
        chk("abort_stb_on", {29'd0, S_STB_O}, 32'h4);
        cyc();
        idle_master();
        cyc();
        chk("abort_stb", {29'd0, S_STB_O}, 32'd0);
        chk("abort_ack", {31'd0, M_ACK_O}, 32'd0);
        chk("abort_err", {31'd0, M_ERR_O}, 32'd0);
        cyc();
        chk("abort_ack2", {31'd0, M_ACK_O}, 32'd0);
        chk("abort_err2", {31'd0, M_ERR_O}, 32'd0);

        // Reset mid-transaction
        req(32'h0000_0100, 32'h0000_0077, 4'b0011, 1'b1);
        cyc();
        chk("mid_stb_on", {29'd0, S_STB_O}, 32'h1);
        RST_I = 1'b0; idle_master();
        cyc();
        chk("mid_rst_stb",  {29'd0, S_STB_O}, 32'd0);
        chk("mid_rst_mdat", M_DAT_O, 32'd0);
        chk("mid_rst_adr",  S_ADR_O, 32'd0);
        chk("mid_rst_sdat", S_DAT_O, 32'd0);
        chk("mid_rst_we",   {31'd0, S_WE_O}, 32'd0);
        chk("mid_rst_sel",  {28'd0, S_SEL_O}, 32'd0);
        RST_I = 1'b1; S_ACK_I = 3'b001;
        cyc();
        chk("post_rst_ack", {31'd0, M_ACK_O}, 32'd0);
        chk("post_rst_err", {31'd0, M_ERR_O}, 32'd0);
        cyc();
        chk("post_rst_ack2", {31'd0, M_ACK_O}, 32'd0);
        chk("post_rst_stb",  {29'd0, S_STB_O}, 32'd0);
        S_ACK_I = '0;

        // Back-to-back reads after the first completes
        req(32'h0000_0040, 32'h0, 4'b1111, 1'b0);
        S_ACK_I = 3'b001; S0_DAT_I = 32'h0000_0040;
        cyc();
        cyc();
        chk("b2b1_ack", {31'd0, M_ACK_O}, 32'h1);
        idle_master(); S_ACK_I = '0;
        cyc();
        req(32'h0000_0044, 32'h0, 4'b1111, 1'b0);
        S_ACK_I = 3'b001; S0_DAT_I = 32'h0000_0044;
        cyc();
        cyc();
        chk("b2b2_ack",  {31'd0, M_ACK_O}, 32'h1);
        chk("b2b2_mdat", M_DAT_O, 32'h0000_0044);
        idle_master(); S_ACK_I = '0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
